pc_unit: RTL and testbench

- Parametrised fetch-PC generator for the pipelined RISC-V core; successor to the single-register PC/NPC pair.
- Holds the fetch PC and selects the next PC from trap, EX-stage redirect, ID-stage return prediction, stall-hold or sequential +4.
- Contains a return-address stack (RAS) and a boot state machine; drives the IF-stage PC and flush request.

---
 rtl/pc_unit_if.sv | 40 ++++
 rtl/pc_unit.sv | 155 +++++++++++++++
 tb/tb_pc_unit.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_unit_if.sv
// Fetch-PC bus between the core control logic (master) and the PC unit (slave).
interface pc_unit_if #(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned RAS_DEPTH = 4
);

   localparam int unsigned CntW = $clog2(RAS_DEPTH) + 1;

   // Control-flow requests into the PC unit
   logic            stall;
   logic            trap_valid;
   logic [XLEN-1:0] trap_vec;
   logic [1:0]      ex_op;
   logic            ex_taken;
   logic [XLEN-1:0] ex_pc;
   logic [XLEN-1:0] ex_imm;
   logic [XLEN-1:0] ex_alu;
   logic            ex_link;
   logic            id_ret;

   // Fetch-side results from the PC unit
   logic [XLEN-1:0] pc;
   logic            pc_valid;
   logic            flush;
   logic            misalign;
   logic [CntW-1:0] ras_count;

   modport master (
      output stall, trap_valid, trap_vec, ex_op, ex_taken, ex_pc, ex_imm, ex_alu,
             ex_link, id_ret,
      input  pc, pc_valid, flush, misalign, ras_count
   );

   modport slave (
      input  stall, trap_valid, trap_vec, ex_op, ex_taken, ex_pc, ex_imm, ex_alu,
             ex_link, id_ret,
      output pc, pc_valid, flush, misalign, ras_count
   );

endinterface

// File: rtl/pc_unit.sv
// Fetch-PC generator: boot FSM, prioritised next-PC selection and a circular
// return-address stack used to predict returns decoded in ID.
module pc_unit #(
   parameter int unsigned     XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = '0,
   parameter int unsigned     RAS_DEPTH = 4
) (
   input logic        clk,
   input logic        rst,
   pc_unit_if.slave   bus
);

   localparam int unsigned PtrW = $clog2(RAS_DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   localparam logic [1:0] OpNone   = 2'b00;
   localparam logic [1:0] OpBranch = 2'b01;
   localparam logic [1:0] OpJal    = 2'b10;
   localparam logic [1:0] OpJalr   = 2'b11;

   typedef enum logic [0:0] {StBoot, StRun} state_e;

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;

   // RAS: ptr_q is the next slot to write; the top of stack sits at ptr_q - 1.
   logic [XLEN-1:0] ras_q [RAS_DEPTH];
   logic [XLEN-1:0] ras_d [RAS_DEPTH];
   logic [PtrW-1:0] ptr_q, ptr_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   logic            run;
   logic            ex_redirect;
   logic [XLEN-1:0] ex_target;
   logic [XLEN-1:0] link_addr;
   logic [PtrW-1:0] ptr_top;
   logic [XLEN-1:0] ras_top;
   logic            ras_hit;
   logic            flush;
   logic            misalign;
   logic            do_push;
   logic            do_pop;
   logic            do_clear;

   // Decode the EX-stage control-flow request and the RAS prediction candidate
   always_comb begin
      run         = (state_q == StRun);
      ex_redirect = 1'b0;
      unique case (bus.ex_op)
         OpNone:   ex_redirect = 1'b0;
         OpBranch: ex_redirect = bus.ex_taken;
         OpJal:    ex_redirect = 1'b1;
         OpJalr:   ex_redirect = 1'b1;
         default:  ex_redirect = 1'b0;
      endcase
      if (bus.ex_op == OpJalr) begin
         ex_target = {bus.ex_alu[XLEN-1:1], 1'b0};
      end else begin
         ex_target = bus.ex_pc + bus.ex_imm;
      end
      link_addr = bus.ex_pc + XLEN'(4);
      ptr_top   = ptr_q - PtrW'(1);
      ras_top   = ras_q[ptr_top];
      ras_hit   = bus.id_ret && (cnt_q != '0);
   end

   // Boot sequencing and next-PC priority: trap > EX redirect > RAS > stall > +4
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      flush    = 1'b0;
      misalign = 1'b0;
      do_push  = 1'b0;
      do_pop   = 1'b0;
      do_clear = 1'b0;
      unique case (state_q)
         StBoot: begin
            state_d = StRun;
         end
         StRun: begin
            if (bus.trap_valid) begin
               pc_d     = bus.trap_vec;
               flush    = 1'b1;
               do_clear = 1'b1;
            end else if (ex_redirect) begin
               pc_d     = ex_target;
               flush    = 1'b1;
               misalign = ex_target[1];
               do_push  = bus.ex_op[1] && bus.ex_link;
            end else if (ras_hit) begin
               pc_d   = ras_top;
               flush  = 1'b1;
               do_pop = 1'b1;
            end else if (bus.stall) begin
               pc_d = pc_q;
            end else begin
               pc_d = pc_q + XLEN'(4);
            end
         end
         default: begin
            state_d = StBoot;
         end
      endcase
   end

   // RAS update: trap clears occupancy, push overwrites oldest when full
   always_comb begin
      ras_d = ras_q;
      ptr_d = ptr_q;
      cnt_d = cnt_q;
      if (do_clear) begin
         cnt_d = '0;
      end else if (do_push) begin
         ras_d[ptr_q] = link_addr;
         ptr_d        = ptr_q + PtrW'(1);
         if (cnt_q != CntW'(RAS_DEPTH)) begin
            cnt_d = cnt_q + CntW'(1);
         end
      end else if (do_pop) begin
         ptr_d = ptr_top;
         cnt_d = cnt_q - CntW'(1);
      end
   end

   // State, PC and RAS registers with asynchronous active-high reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StBoot;
         pc_q    <= RESET_PC;
         ptr_q   <= '0;
         cnt_q   <= '0;
         for (int i = 0; i < int'(RAS_DEPTH); i++) begin
            ras_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         for (int i = 0; i < int'(RAS_DEPTH); i++) begin
            ras_q[i] <= ras_d[i];
         end
      end
   end

   // Drive the fetch-side outputs
   always_comb begin
      bus.pc        = pc_q;
      bus.pc_valid  = run;
      bus.flush     = flush;
      bus.misalign  = misalign;
      bus.ras_count = cnt_q;
   end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: boot, stall/redirect, call/return RAS, priority and wrap.
module tb_pc_unit;

   localparam int unsigned XLEN = 32;
   localparam int unsigned RAS_DEPTH = 4;
   localparam logic [31:0] RST_PC = 32'h0000_0100;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   pc_unit_if #(.XLEN(XLEN), .RAS_DEPTH(RAS_DEPTH)) bus_if ();

   pc_unit #(.XLEN(XLEN), .RESET_PC(RST_PC), .RAS_DEPTH(RAS_DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus_if.stall      = 1'b0;
      bus_if.trap_valid = 1'b0;
      bus_if.trap_vec   = '0;
      bus_if.ex_op      = 2'b00;
      bus_if.ex_taken   = 1'b0;
      bus_if.ex_pc      = '0;
      bus_if.ex_imm     = '0;
      bus_if.ex_alu     = '0;
      bus_if.ex_link    = 1'b0;
      bus_if.id_ret     = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] exp_pc [3];
      exp_pc[0] = 32'h100; exp_pc[1] = 32'h104; exp_pc[2] = 32'h108;
      rst = 1'b1;
      clear_inputs();
      step();
      checks++;
      if (bus_if.pc !== RST_PC || bus_if.pc_valid !== 1'b0 || bus_if.flush !== 1'b0 ||
          bus_if.ras_count !== 3'd0) begin
         failures++;
         $display("FAIL reset_state: pc=%h valid=%b flush=%b cnt=%0d, want pc=%h valid=0 flush=0 cnt=0",
                  bus_if.pc, bus_if.pc_valid, bus_if.flush, bus_if.ras_count, RST_PC);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (bus_if.pc !== 32'h100 || bus_if.pc_valid !== 1'b0) begin
         failures++;
         $display("FAIL boot_cycle: pc=%h valid=%b, want pc=00000100 valid=0",
                  bus_if.pc, bus_if.pc_valid);
      end
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (bus_if.pc !== exp_pc[i] || bus_if.pc_valid !== 1'b1) begin
            failures++;
            $display("FAIL run_step%0d: pc=%h valid=%b, want pc=%h valid=1",
                     i, bus_if.pc, bus_if.pc_valid, exp_pc[i]);
         end
      end
   endtask

   task automatic test_stall_redirect();
      bus_if.stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (bus_if.pc !== 32'h108 || bus_if.flush !== 1'b0) begin
            failures++;
            $display("FAIL stall_hold%0d: pc=%h flush=%b, want pc=00000108 flush=0",
                     i, bus_if.pc, bus_if.flush);
         end
      end
      bus_if.ex_op    = 2'b01;
      bus_if.ex_taken = 1'b1;
      bus_if.ex_pc    = 32'h104;
      bus_if.ex_imm   = 32'hFFFF_FFF8;
      #1;
      checks++;
      if (bus_if.flush !== 1'b1 || bus_if.misalign !== 1'b0) begin
         failures++;
         $display("FAIL stall_branch_flush: flush=%b misalign=%b, want flush=1 misalign=0",
                  bus_if.flush, bus_if.misalign);
      end
      step();
      clear_inputs();
      checks++;
      if (bus_if.pc !== 32'hFC) begin
         failures++;
         $display("FAIL stall_branch_pc: pc=%h, want 000000fc", bus_if.pc);
      end
   endtask

   task automatic test_branch_jalr();
      bus_if.ex_op    = 2'b01;
      bus_if.ex_taken = 1'b0;
      bus_if.ex_pc    = 32'h80;
      bus_if.ex_imm   = 32'h40;
      #1;
      checks++;
      if (bus_if.flush !== 1'b0) begin
         failures++;
         $display("FAIL branch_nt_flush: flush=%b, want 0", bus_if.flush);
      end
      step();
      checks++;
      if (bus_if.pc !== 32'h100) begin
         failures++;
         $display("FAIL branch_nt_pc: pc=%h, want 00000100", bus_if.pc);
      end
      clear_inputs();
      bus_if.ex_op  = 2'b11;
      bus_if.ex_alu = 32'h2003;
      #1;
      checks++;
      if (bus_if.flush !== 1'b1 || bus_if.misalign !== 1'b1) begin
         failures++;
         $display("FAIL jalr_flags: flush=%b misalign=%b, want flush=1 misalign=1",
                  bus_if.flush, bus_if.misalign);
      end
      step();
      clear_inputs();
      #1;
      checks++;
      if (bus_if.pc !== 32'h2002 || bus_if.misalign !== 1'b0) begin
         failures++;
         $display("FAIL jalr_pc: pc=%h misalign=%b, want pc=00002002 misalign=0",
                  bus_if.pc, bus_if.misalign);
      end
   endtask

   task automatic test_call_return();
      bus_if.ex_op   = 2'b10;
      bus_if.ex_pc   = 32'h40;
      bus_if.ex_imm  = 32'h100;
      bus_if.ex_link = 1'b1;
      step();
      clear_inputs();
      checks++;
      if (bus_if.pc !== 32'h140 || bus_if.ras_count !== 3'd1) begin
         failures++;
         $display("FAIL call_pc: pc=%h cnt=%0d, want pc=00000140 cnt=1",
                  bus_if.pc, bus_if.ras_count);
      end
      step();
      bus_if.id_ret = 1'b1;
      #1;
      checks++;
      if (bus_if.flush !== 1'b1) begin
         failures++;
         $display("FAIL ret_flush: flush=%b, want 1", bus_if.flush);
      end
      step();
      checks++;
      if (bus_if.pc !== 32'h44 || bus_if.ras_count !== 3'd0) begin
         failures++;
         $display("FAIL ret_pc: pc=%h cnt=%0d, want pc=00000044 cnt=0",
                  bus_if.pc, bus_if.ras_count);
      end
      checks++;
      if (bus_if.flush !== 1'b0) begin
         failures++;
         $display("FAIL empty_ret_flush: flush=%b, want 0", bus_if.flush);
      end
      step();
      clear_inputs();
      checks++;
      if (bus_if.pc !== 32'h48 || bus_if.ras_count !== 3'd0) begin
         failures++;
         $display("FAIL empty_ret_pc: pc=%h cnt=%0d, want pc=00000048 cnt=0",
                  bus_if.pc, bus_if.ras_count);
      end
   endtask

   task automatic test_ras_overflow();
      logic [31:0] exp_ret [4];
      exp_ret[0] = 32'h54; exp_ret[1] = 32'h44; exp_ret[2] = 32'h34; exp_ret[3] = 32'h24;
      for (int i = 0; i < 5; i++) begin
         bus_if.ex_op   = 2'b10;
         bus_if.ex_pc   = 32'(16 * (i + 1));
         bus_if.ex_imm  = 32'h1000;
         bus_if.ex_link = 1'b1;
         step();
      end
      clear_inputs();
      checks++;
      if (bus_if.ras_count !== 3'd4) begin
         failures++;
         $display("FAIL ras_full_count: cnt=%0d, want 4", bus_if.ras_count);
      end
      bus_if.id_ret = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (bus_if.pc !== exp_ret[i]) begin
            failures++;
            $display("FAIL ras_pop%0d: pc=%h, want %h", i, bus_if.pc, exp_ret[i]);
         end
      end
      clear_inputs();
      checks++;
      if (bus_if.ras_count !== 3'd0) begin
         failures++;
         $display("FAIL ras_drained: cnt=%0d, want 0", bus_if.ras_count);
      end
   endtask

   task automatic test_back_to_back();
      // jalr call with link pushes ex_pc+4, immediately followed by a branch redirect
      bus_if.ex_op   = 2'b11;
      bus_if.ex_pc   = 32'h300;
      bus_if.ex_alu  = 32'h501;
      bus_if.ex_link = 1'b1;
      step();
      clear_inputs();
      bus_if.ex_op    = 2'b01;
      bus_if.ex_taken = 1'b1;
      bus_if.ex_pc    = 32'h500;
      bus_if.ex_imm   = 32'h20;
      #1;
      checks++;
      if (bus_if.pc !== 32'h500 || bus_if.ras_count !== 3'd1 || bus_if.flush !== 1'b1) begin
         failures++;
         $display("FAIL b2b_first: pc=%h cnt=%0d flush=%b, want pc=00000500 cnt=1 flush=1",
                  bus_if.pc, bus_if.ras_count, bus_if.flush);
      end
      step();
      clear_inputs();
      bus_if.id_ret = 1'b1;
      step();
      clear_inputs();
      checks++;
      if (bus_if.pc !== 32'h304 || bus_if.ras_count !== 3'd0) begin
         failures++;
         $display("FAIL b2b_return: pc=%h cnt=%0d, want pc=00000304 cnt=0",
                  bus_if.pc, bus_if.ras_count);
      end
   endtask

   task automatic test_priority_wrap();
      bus_if.ex_op   = 2'b10;
      bus_if.ex_pc   = 32'h60;
      bus_if.ex_imm  = 32'h10;
      bus_if.ex_link = 1'b1;
      step();
      // trap, linked EX redirect and return all at once
      bus_if.trap_valid = 1'b1;
      bus_if.trap_vec   = 32'h800;
      bus_if.ex_pc      = 32'h70;
      bus_if.id_ret     = 1'b1;
      #1;
      checks++;
      if (bus_if.flush !== 1'b1 || bus_if.misalign !== 1'b0) begin
         failures++;
         $display("FAIL prio_flags: flush=%b misalign=%b, want flush=1 misalign=0",
                  bus_if.flush, bus_if.misalign);
      end
      step();
      clear_inputs();
      checks++;
      if (bus_if.pc !== 32'h800 || bus_if.ras_count !== 3'd0) begin
         failures++;
         $display("FAIL prio_trap: pc=%h cnt=%0d, want pc=00000800 cnt=0",
                  bus_if.pc, bus_if.ras_count);
      end
      bus_if.trap_valid = 1'b1;
      bus_if.trap_vec   = 32'hFFFF_FFFC;
      step();
      clear_inputs();
      step();
      checks++;
      if (bus_if.pc !== 32'h0) begin
         failures++;
         $display("FAIL pc_wrap: pc=%h, want 00000000", bus_if.pc);
      end
      bus_if.ex_op  = 2'b10;
      bus_if.ex_pc  = 32'h200;
      bus_if.ex_imm = 32'h40;
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (bus_if.pc !== RST_PC || bus_if.pc_valid !== 1'b0 || bus_if.flush !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset: pc=%h valid=%b flush=%b, want pc=%h valid=0 flush=0",
                  bus_if.pc, bus_if.pc_valid, bus_if.flush, RST_PC);
      end
      step();
      clear_inputs();
      rst = 1'b0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      clear_inputs();
      test_reset();
      test_stall_redirect();
      test_branch_jalr();
      test_call_return();
      test_ras_overflow();
      test_back_to_back();
      test_priority_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
